// File: rtl/regfile_scan_pkg.sv
// Shared datapath sizing for the register file and its debug read-out initiator.
package regfile_scan_pkg;

  // Register file geometry shared across the datapath.
  localparam int RF_WIDTH      = 32;
  localparam int RF_ADDR_WIDTH = 5;

endpackage : regfile_scan_pkg

// File: rtl/regfile_scan.sv
// Debug read-out initiator: sweeps the register file read port on a start
// pulse and streams {address, data} pairs over a valid/ready interface.
module regfile_scan
  import regfile_scan_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  skipZero,
  output logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [WIDTH-1:0]      readData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic [WIDTH-1:0]      outData,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state, address counter and output-capture logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        // abort is deliberately ignored here so start always wins.
        if (start) begin
          addr_d  = skipZero ? ADDR_ONE : ADDR_ZERO;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          // readData is combinational from readAddr, so it is captured here.
          out_data_d  = readData;
          out_addr_d  = addr_q;
          out_last_d  = (addr_q == ADDR_LAST);
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else if (outReady) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            // Never wraps: the all-ones word ends the scan before increment.
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset is asynchronous on assertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_ZERO;
      out_valid_q <= 1'b0;
      out_addr_q  <= ADDR_ZERO;
      out_data_q  <= {WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign readAddr = addr_q;
  assign outValid = out_valid_q;
  assign outAddr  = out_addr_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : regfile_scan

// File: tb/tb_regfile_scan.sv
// Directed self-checking bench for regfile_scan with a small regfile model.
module tb_regfile_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        skipZero;
  logic [4:0]  readAddr;
  logic [31:0] readData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  outAddr;
  logic [31:0] outData;
  logic        outLast;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int errors = 0;
  int checks = 0;

  regfile_scan dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .skipZero (skipZero),
    .readAddr (readAddr),
    .readData (readData),
    .outValid (outValid),
    .outReady (outReady),
    .outAddr  (outAddr),
    .outData  (outData),
    .outLast  (outLast),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file model: clocked write port, combinational read port.
  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  assign readData = mem[readAddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wa = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Runs one scan. exp_done < 0 skips the done-timing check; restart_at
  // re-pulses start (with skipZero) at that cycle to show it is ignored.
  task automatic do_scan(input string tag, input bit skip, input bit bp,
                         input int exp_done, input int restart_at);
    int idx;
    int n;
    int done_seen;
    int done_cnt;
    bit prev_stall;
    bit rdy;
    logic [31:0] prev_data;
    logic [4:0]  prev_addr;
    idx = skip ? 1 : 0;
    done_seen = -1;
    done_cnt = 0;
    prev_stall = 1'b0;
    prev_data = 32'd0;
    prev_addr = 5'd0;
    outReady = 1'b1;
    start = 1'b1; skipZero = skip;
    @(negedge clk);
    start = 1'b0; skipZero = 1'b0;
    n = 1;
    check({tag, " busy after start"}, {63'd0, busy}, 64'd1);
    while (n < 600 && done_seen < 0) begin
      rdy = 1'b1;
      if (outValid) begin
        if (prev_stall) begin
          check({tag, " stall data stable"}, {32'd0, outData}, {32'd0, prev_data});
          check({tag, " stall addr stable"}, {59'd0, outAddr}, {59'd0, prev_addr});
        end
        rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy) begin
          check({tag, " word addr"}, {59'd0, outAddr}, 64'(idx));
          check({tag, " word data"}, {32'd0, outData}, {32'd0, 32'hA5A50000 + 32'(idx)});
          check({tag, " word last"}, {63'd0, outLast}, {63'd0, idx == 31});
          idx++;
        end
        prev_stall = !rdy;
        prev_data = outData;
        prev_addr = outAddr;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        done_seen = n;
        done_cnt++;
      end
      outReady = rdy;
      start = (n == restart_at);
      skipZero = (n == restart_at);
      @(negedge clk);
      start = 1'b0; skipZero = 1'b0;
      n++;
    end
    check({tag, " done seen"}, {63'd0, done_seen >= 0}, 64'd1);
    check({tag, " word count"}, 64'(idx), 64'd32);
    if (exp_done >= 0) check({tag, " done cycle"}, 64'(done_seen), 64'(exp_done));
    check({tag, " done single pulse"}, {63'd0, done}, 64'd0);
    check({tag, " busy drops"}, {63'd0, busy}, 64'd0);
    outReady = 1'b1;
  endtask

  // Streams a scan with a write to register 9 on its LOAD edge (early=0)
  // or one cycle before it (early=1), and checks the streamed word 9.
  task automatic write_race(input string tag, input bit early, input logic [31:0] exp9);
    int n;
    bit wrote;
    logic [31:0] got9;
    wrote = 1'b0;
    got9 = 32'd0;
    outReady = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 200 && !done) begin
      we = 1'b0;
      if (!wrote && !early && busy && !outValid && readAddr == 5'd9) begin
        we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF; wrote = 1'b1;
      end
      if (!wrote && early && outValid && outAddr == 5'd8) begin
        we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF; wrote = 1'b1;
      end
      if (outValid && outAddr == 5'd9) got9 = outData;
      @(negedge clk);
      n++;
    end
    we = 1'b0;
    check({tag, " done reached"}, {63'd0, done}, 64'd1);
    check({tag, " word 9"}, {32'd0, got9}, {32'd0, exp9});
    @(negedge clk);
    write_reg(5'd9, 32'hA5A50009);
  endtask

  initial begin
    int n;
    bit saw_done;
    reset = 1'b0; start = 1'b0; abort = 1'b0; skipZero = 1'b0;
    outReady = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'd0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) write_reg(5'(k), 32'hA5A50000 + 32'(k));

    check("reset outValid", {63'd0, outValid}, 64'd0);
    check("reset busy",     {63'd0, busy}, 64'd0);
    check("reset done",     {63'd0, done}, 64'd0);
    check("reset readAddr", {59'd0, readAddr}, 64'd0);
    check("reset outData",  {32'd0, outData}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_scan("full", 1'b0, 1'b0, 65, -1);
    do_scan("skip", 1'b1, 1'b0, 63, -1);
    do_scan("bp",   1'b0, 1'b1, -1, -1);
    do_scan("restart_ignored", 1'b0, 1'b0, 65, 3);

    // Abort while holding word 10.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(outValid && outAddr == 5'd10)) begin
      @(negedge clk);
      n++;
    end
    check("abort reached addr 10", {59'd0, outAddr}, 64'd10);
    outReady = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; outReady = 1'b1;
    check("abort outValid", {63'd0, outValid}, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort addr kept", {59'd0, readAddr}, 64'd10);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort no done", {63'd0, saw_done}, 64'd0);
    do_scan("after_abort", 1'b0, 1'b0, 65, -1);

    write_race("race_same", 1'b0, 32'hA5A50009);
    write_race("race_early", 1'b1, 32'hDEADBEEF);

    // Asynchronous reset while holding word 7.
    outReady = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(outValid && outAddr == 5'd7)) begin
      @(negedge clk);
      n++;
    end
    outReady = 1'b0;
    @(negedge clk);
    check("hold at 7", {59'd0, outAddr}, 64'd7);
    #2 reset = 1'b0;
    #1;
    check("async rst outValid", {63'd0, outValid}, 64'd0);
    check("async rst outAddr",  {59'd0, outAddr}, 64'd0);
    check("async rst outData",  {32'd0, outData}, 64'd0);
    check("async rst outLast",  {63'd0, outLast}, 64'd0);
    check("async rst readAddr", {59'd0, readAddr}, 64'd0);
    check("async rst busy",     {63'd0, busy}, 64'd0);
    check("async rst done",     {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    do_scan("after_reset", 1'b0, 1'b0, 65, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_scan
